// File: rtl/igmp_pkg.sv
// Shared IGMP constants, slot-state encoding and the response-delay helpers
// used by the report scheduler and its arbiter.
package igmp_pkg;

   localparam logic [7:0] IGMP_TYPE_QUERY     = 8'h11;
   localparam logic [7:0] IGMP_TYPE_V2_REPORT = 8'h16;
   localparam logic [7:0] IGMP_TYPE_LEAVE     = 8'h17;

   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
   localparam logic [7:0] LFSR_POLY = 8'hB8;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_MEMBER  = 2'd1,
      SLOT_DELAY   = 2'd2,
      SLOT_PENDING = 2'd3
   } slot_state_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
   endfunction

   // d = lfsr * (mrc_e + 1) >> 8, with mrc_e clamped to 127, so d <= mrc_e.
   function automatic logic [6:0] resp_delay(input logic [7:0] lfsr,
                                             input logic [7:0] mrc);
      logic [7:0]  mrc_p1;
      logic [15:0] prod;
      mrc_p1 = mrc[7] ? 8'd128 : ({1'b0, mrc[6:0]} + 8'd1);
      prod   = {8'h00, lfsr} * {8'h00, mrc_p1};
      return 7'(prod >> 8);
   endfunction

endpackage

// File: rtl/igmp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the slot after the last
// accepted one; remembers which slot owns the presented message.
module igmp_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         take,
   input  logic         accept,
   output logic [N-1:0] grant,
   output logic [N-1:0] owner
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic             found;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_next = ptr;
      for (int i = 0; i < N; i++) begin
         if (owner[i]) ptr_next = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         owner <= '0;
      end else begin
         if (take)   owner <= grant;
         if (accept) ptr   <= ptr_next;
      end
   end

endmodule

// File: rtl/igmp_report_scheduler.sv
// Per-group IGMP host state (join/leave/query/timer) with a round-robin
// scheduled single-message output towards the transmit builder.
module igmp_report_scheduler
   import igmp_pkg::*;
#(
   parameter int         NUM_GROUPS = 4,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  cfg_valid,
   input  logic                  cfg_join,
   input  logic [31:0]           cfg_group,
   output logic                  cfg_err,
   input  logic                  q_valid,
   input  logic [7:0]            q_mrc,
   input  logic [31:0]           q_group,
   output logic                  rpt_valid,
   input  logic                  rpt_ready,
   output logic [7:0]            rpt_type,
   output logic [31:0]           rpt_group,
   output logic [NUM_GROUPS-1:0] active_map
);

   slot_state_t state_q [NUM_GROUPS];
   slot_state_t state_d [NUM_GROUPS];
   logic [31:0] grp_q   [NUM_GROUPS];
   logic [31:0] grp_d   [NUM_GROUPS];
   logic [6:0]  cnt_q   [NUM_GROUPS];
   logic [6:0]  cnt_d   [NUM_GROUPS];
   logic [7:0]  mtype_q [NUM_GROUPS];
   logic [7:0]  mtype_d [NUM_GROUPS];

   logic [7:0]            lfsr;
   logic [6:0]            q_delay;
   logic [NUM_GROUPS-1:0] cfg_match, first_free, q_hit, req, grant, owner;
   logic                  ff_found, join_ok, leave_ok, take, accept;
   logic [7:0]            sel_type;
   logic [31:0]           sel_group;

   assign q_delay = resp_delay(lfsr, q_mrc);
   assign take    = !rpt_valid && (|req);
   assign accept  = rpt_valid && rpt_ready;

   // Command and query decode against the current slot table.
   always_comb begin
      cfg_match  = '0;
      first_free = '0;
      q_hit      = '0;
      ff_found   = 1'b0;
      for (int i = 0; i < NUM_GROUPS; i++) begin
         cfg_match[i] = (state_q[i] != SLOT_FREE) && (grp_q[i] == cfg_group);
         q_hit[i]     = q_valid &&
                        ((state_q[i] == SLOT_MEMBER) || (state_q[i] == SLOT_DELAY)) &&
                        ((q_group == 32'h0) || (grp_q[i] == q_group));
         if (!ff_found && (state_q[i] == SLOT_FREE)) begin
            first_free[i] = 1'b1;
            ff_found      = 1'b1;
         end
      end
      join_ok  = cfg_valid && cfg_join && (cfg_match == '0) && ff_found;
      leave_ok = cfg_valid && !cfg_join && (|cfg_match);
   end

   // Per-slot next state; priority cfg > handshake > query > tick.
   always_comb begin
      for (int i = 0; i < NUM_GROUPS; i++) begin
         state_d[i] = state_q[i];
         grp_d[i]   = grp_q[i];
         cnt_d[i]   = cnt_q[i];
         mtype_d[i] = mtype_q[i];
         if ((join_ok && first_free[i]) || (leave_ok && cfg_match[i])) begin
            state_d[i] = SLOT_PENDING;
            mtype_d[i] = join_ok ? IGMP_TYPE_V2_REPORT : IGMP_TYPE_LEAVE;
            if (join_ok) begin
               grp_d[i] = cfg_group;
               cnt_d[i] = '0;
            end
         end else if (accept && owner[i]) begin
            // A leave that arrived while a report was presented stays queued.
            if (mtype_q[i] == IGMP_TYPE_V2_REPORT) begin
               state_d[i] = SLOT_MEMBER;
            end else if (rpt_type == IGMP_TYPE_LEAVE) begin
               state_d[i] = SLOT_FREE;
               grp_d[i]   = '0;
            end
         end else if (q_hit[i]) begin
            if (q_delay == 7'd0) begin
               state_d[i] = SLOT_PENDING;
               mtype_d[i] = IGMP_TYPE_V2_REPORT;
            end else if ((state_q[i] == SLOT_MEMBER) || (q_delay < cnt_q[i])) begin
               state_d[i] = SLOT_DELAY;
               cnt_d[i]   = q_delay;
            end
         end else if (tick && (state_q[i] == SLOT_DELAY)) begin
            if (cnt_q[i] == 7'd1) begin
               state_d[i] = SLOT_PENDING;
               mtype_d[i] = IGMP_TYPE_V2_REPORT;
            end else begin
               cnt_d[i] = cnt_q[i] - 7'd1;
            end
         end
      end
   end

   // NOTE: the slot table is small and must be discarded by reset, so it
   // lives in flops with a reset rather than in an unreset RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_GROUPS; i++) begin
            state_q[i] <= SLOT_FREE;
            grp_q[i]   <= '0;
            cnt_q[i]   <= '0;
            mtype_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_GROUPS; i++) begin
            state_q[i] <= state_d[i];
            grp_q[i]   <= grp_d[i];
            cnt_q[i]   <= cnt_d[i];
            mtype_q[i] <= mtype_d[i];
         end
      end
   end

   always_comb begin
      req        = '0;
      active_map = '0;
      sel_type   = '0;
      sel_group  = '0;
      for (int i = 0; i < NUM_GROUPS; i++) begin
         req[i]        = (state_q[i] == SLOT_PENDING) && !(rpt_valid && owner[i]);
         active_map[i] = (state_q[i] != SLOT_FREE);
         if (grant[i]) begin
            sel_type  = sel_type | mtype_q[i];
            sel_group = sel_group | grp_q[i];
         end
      end
   end

   igmp_rr_arbiter #(.N(NUM_GROUPS)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .take   (take),
      .accept (accept),
      .grant  (grant),
      .owner  (owner)
   );

   // Message register only reloads once the previous message is gone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr      <= LFSR_SEED;
         cfg_err   <= 1'b0;
         rpt_valid <= 1'b0;
         rpt_type  <= '0;
         rpt_group <= '0;
      end else begin
         lfsr    <= lfsr_step(lfsr);
         cfg_err <= cfg_valid && !(join_ok || leave_ok);
         if (take) begin
            rpt_valid <= 1'b1;
            rpt_type  <= sel_type;
            rpt_group <= sel_group;
         end else if (accept) begin
            rpt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_igmp_report_scheduler.sv
// Directed bench for igmp_report_scheduler: table-driven join/leave vectors
// plus hand-written query, timer, back-pressure and reset sequences.
module tb_igmp_report_scheduler;

   localparam logic [7:0]  T_RPT = 8'h16;
   localparam logic [7:0]  T_LV  = 8'h17;
   localparam logic [31:0] G_A   = 32'hE000_0101;
   localparam logic [31:0] G_B   = 32'hE000_0102;
   localparam logic [31:0] G_C   = 32'hE000_0103;
   localparam logic [31:0] G_D   = 32'hE000_0104;
   localparam logic [31:0] G_E   = 32'hE000_0105;
   localparam int          NV    = 21;

   typedef enum logic [1:0] {OP_NOP, OP_JOIN, OP_LEAVE} op_t;

   typedef struct {
      op_t         op;
      logic [31:0] grp;
      logic        rdy;
      logic        ev;
      logic [7:0]  et;
      logic [31:0] eg;
      logic        ee;
      logic [3:0]  em;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_join = 1'b0;
   logic [31:0] cfg_group = '0;
   logic        cfg_err;
   logic        q_valid = 1'b0;
   logic [7:0]  q_mrc = '0;
   logic [31:0] q_group = '0;
   logic        rpt_valid;
   logic        rpt_ready = 1'b0;
   logic [7:0]  rpt_type;
   logic [31:0] rpt_group;
   logic [3:0]  active_map;

   logic [7:0]  m_lfsr;
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        vt [NV];

   always #5 clk = ~clk;

   igmp_report_scheduler #(.NUM_GROUPS(4), .LFSR_SEED(8'hA5)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .cfg_valid  (cfg_valid),
      .cfg_join   (cfg_join),
      .cfg_group  (cfg_group),
      .cfg_err    (cfg_err),
      .q_valid    (q_valid),
      .q_mrc      (q_mrc),
      .q_group    (q_group),
      .rpt_valid  (rpt_valid),
      .rpt_ready  (rpt_ready),
      .rpt_type   (rpt_type),
      .rpt_group  (rpt_group),
      .active_map (active_map)
   );

   // Reference LFSR: x^8+x^6+x^5+x^4+1, Galois, seeded 8'hA5.
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr = 8'hA5;
      else     m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
   end

   function automatic int calc_d(input logic [7:0] l, input int mrc);
      int me;
      me = (mrc < 128) ? mrc : 127;
      return (int'(l) * (me + 1)) >> 8;
   endfunction

   function automatic vec_t mk(input op_t op, input logic [31:0] g, input logic rdy,
                               input logic ev, input logic [7:0] et, input logic [31:0] eg,
                               input logic ee, input logic [3:0] em);
      vec_t v;
      v.op = op; v.grp = g; v.rdy = rdy; v.ev = ev;
      v.et = et; v.eg = eg; v.ee = ee; v.em = em;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick = 1'b0; cfg_valid = 1'b0; cfg_join = 1'b0; cfg_group = '0;
      q_valid = 1'b0; q_mrc = '0; q_group = '0; rpt_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic cfg_cmd(input op_t op, input logic [31:0] g);
      cfg_valid = 1'b1; cfg_join = (op == OP_JOIN); cfg_group = g;
      cycle();
      cfg_valid = 1'b0; cfg_join = 1'b0; cfg_group = '0;
   endtask

   task automatic query(input logic [31:0] g, input int mrc, input logic tk);
      q_valid = 1'b1; q_group = g; q_mrc = 8'(mrc); tick = tk;
      cycle();
      q_valid = 1'b0; q_group = '0; q_mrc = '0; tick = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cycle();
      end
      tick = 1'b0;
   endtask

   // Waits until the reference LFSR yields a delay in [lo, hi] for this mrc.
   task automatic wait_d(input string nm, input int mrc, input int lo, input int hi,
                         output int d);
      int n = 0;
      while (!((calc_d(m_lfsr, mrc) >= lo) && (calc_d(m_lfsr, mrc) <= hi)) && (n < 600)) begin
         cycle();
         n++;
      end
      check({nm, "_lfsr_wait"}, 64'(n < 600), 64'(1));
      d = calc_d(m_lfsr, mrc);
   endtask

   task automatic expect_now(input string nm, input logic [7:0] t, input logic [31:0] g);
      check({nm, "_valid"}, 64'(rpt_valid), 64'(1));
      check({nm, "_type"},  64'(rpt_type),  64'(t));
      check({nm, "_group"}, 64'(rpt_group), 64'(g));
      rpt_ready = 1'b1;
      cycle();
      rpt_ready = 1'b0;
      check({nm, "_accept"}, 64'(rpt_valid), 64'(0));
   endtask

   task automatic expect_msg(input string nm, input logic [7:0] t, input logic [31:0] g);
      int n = 0;
      while (!rpt_valid && (n < 20)) begin
         cycle();
         n++;
      end
      expect_now(nm, t, g);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;

      vt[0]  = mk(OP_NOP,   32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 4'b0000);
      vt[1]  = mk(OP_JOIN,  G_A,   1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 4'b0001);
      vt[2]  = mk(OP_NOP,   32'h0, 1'b0, 1'b1, T_RPT, G_A,   1'b0, 4'b0001);
      vt[3]  = mk(OP_NOP,   32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 4'b0001);
      vt[4]  = mk(OP_JOIN,  G_B,   1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 4'b0011);
      vt[5]  = mk(OP_JOIN,  G_C,   1'b0, 1'b1, T_RPT, G_B,   1'b0, 4'b0111);
      vt[6]  = mk(OP_JOIN,  G_D,   1'b0, 1'b1, T_RPT, G_B,   1'b0, 4'b1111);
      vt[7]  = mk(OP_JOIN,  G_E,   1'b0, 1'b1, T_RPT, G_B,   1'b1, 4'b1111);
      vt[8]  = mk(OP_NOP,   32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 4'b1111);
      vt[9]  = mk(OP_NOP,   32'h0, 1'b1, 1'b1, T_RPT, G_C,   1'b0, 4'b1111);
      vt[10] = mk(OP_NOP,   32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 4'b1111);
      vt[11] = mk(OP_NOP,   32'h0, 1'b1, 1'b1, T_RPT, G_D,   1'b0, 4'b1111);
      vt[12] = mk(OP_NOP,   32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 4'b1111);
      vt[13] = mk(OP_LEAVE, G_B,   1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 4'b1111);
      vt[14] = mk(OP_NOP,   32'h0, 1'b0, 1'b1, T_LV,  G_B,   1'b0, 4'b1111);
      vt[15] = mk(OP_NOP,   32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 4'b1101);
      vt[16] = mk(OP_LEAVE, G_B,   1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 4'b1101);
      vt[17] = mk(OP_JOIN,  G_A,   1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 4'b1101);
      vt[18] = mk(OP_JOIN,  G_E,   1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 4'b1111);
      vt[19] = mk(OP_NOP,   32'h0, 1'b0, 1'b1, T_RPT, G_E,   1'b0, 4'b1111);
      vt[20] = mk(OP_NOP,   32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 4'b1111);

      // Reset state, sampled while reset is still asserted.
      #12;
      check("rst_valid", 64'(rpt_valid),  64'(0));
      check("rst_type",  64'(rpt_type),   64'(0));
      check("rst_group", 64'(rpt_group),  64'(0));
      check("rst_err",   64'(cfg_err),    64'(0));
      check("rst_map",   64'(active_map), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Join / table full / duplicate / leave vectors.
      for (int i = 0; i < NV; i++) begin
         cfg_valid = (vt[i].op != OP_NOP);
         cfg_join  = (vt[i].op == OP_JOIN);
         cfg_group = vt[i].grp;
         rpt_ready = vt[i].rdy;
         cycle();
         check($sformatf("vec%0d_valid", i), 64'(rpt_valid), 64'(vt[i].ev));
         if (vt[i].ev) begin
            check($sformatf("vec%0d_type", i),  64'(rpt_type),  64'(vt[i].et));
            check($sformatf("vec%0d_group", i), 64'(rpt_group), 64'(vt[i].eg));
         end
         check($sformatf("vec%0d_err", i), 64'(cfg_err),    64'(vt[i].ee));
         check($sformatf("vec%0d_map", i), 64'(active_map), 64'(vt[i].em));
      end
      cfg_valid = 1'b0; cfg_join = 1'b0; cfg_group = '0; rpt_ready = 1'b0;

      // General query on two members; both expire together, served 0 then 1.
      do_reset();
      cfg_cmd(OP_JOIN, G_A);
      cfg_cmd(OP_JOIN, G_B);
      expect_msg("gq_join_a", T_RPT, G_A);
      expect_msg("gq_join_b", T_RPT, G_B);
      wait_d("gq", 100, 3, 127, d);
      query(32'h0, 100, 1'b0);
      run_ticks(d);
      check("gq_quiet", 64'(rpt_valid), 64'(0));
      cycle();
      expect_now("gq_rpt_a", T_RPT, G_A);
      cycle();
      expect_now("gq_rpt_b", T_RPT, G_B);

      // Shorter timer wins: a longer reload is ignored.
      do_reset();
      cfg_cmd(OP_JOIN, G_A);
      expect_msg("st_join", T_RPT, G_A);
      wait_d("st_a10", 20, 10, 10, d);
      query(G_A, 20, 1'b0);
      wait_d("st_big", 50, 11, 127, d);
      query(G_A, 50, 1'b0);
      run_ticks(10);
      check("st_keep_quiet", 64'(rpt_valid), 64'(0));
      cycle();
      expect_now("st_keep", T_RPT, G_A);

      // A shorter reload takes effect and is not decremented by a same-cycle tick.
      wait_d("st_b10", 20, 10, 10, d);
      query(G_A, 20, 1'b0);
      wait_d("st_small", 50, 1, 5, d);
      query(G_A, 50, 1'b1);
      run_ticks(d);
      check("st_reload_quiet", 64'(rpt_valid), 64'(0));
      cycle();
      expect_now("st_reload", T_RPT, G_A);

      // q_mrc above 127 is clamped to 127.
      wait_d("st_clamp", 200, 3, 8, d);
      query(G_A, 200, 1'b0);
      run_ticks(d);
      check("st_clamp_quiet", 64'(rpt_valid), 64'(0));
      cycle();
      expect_now("st_clamp", T_RPT, G_A);

      // Back-pressure: three pending, output held, then served 0, 1, 2.
      do_reset();
      cfg_cmd(OP_JOIN, G_A);
      cfg_cmd(OP_JOIN, G_B);
      cfg_cmd(OP_JOIN, G_C);
      for (int i = 0; i < 20; i++) begin
         cycle();
         check($sformatf("bp_hold%0d", i), {rpt_valid, rpt_type, rpt_group},
               {1'b1, T_RPT, G_A});
      end
      expect_now("bp0", T_RPT, G_A);
      expect_msg("bp1", T_RPT, G_B);
      expect_msg("bp2", T_RPT, G_C);
      check("bp_map", 64'(active_map), 64'(4'b0111));

      // Leave of the slot whose report is being presented.
      do_reset();
      cfg_cmd(OP_JOIN, G_A);
      cycle();
      check("lp_valid", 64'(rpt_valid), 64'(1));
      cfg_cmd(OP_LEAVE, G_A);
      check("lp_hold", {rpt_valid, rpt_type, rpt_group}, {1'b1, T_RPT, G_A});
      check("lp_err", 64'(cfg_err), 64'(0));
      rpt_ready = 1'b1;
      cycle();
      rpt_ready = 1'b0;
      check("lp_acc_valid", 64'(rpt_valid), 64'(0));
      check("lp_acc_map", 64'(active_map), 64'(4'b0001));
      cycle();
      expect_now("lp_requeue", T_LV, G_A);
      check("lp_free_map", 64'(active_map), 64'(4'b0000));

      // Leave of a group whose response timer is running.
      cfg_cmd(OP_JOIN, G_B);
      expect_msg("ld_join", T_RPT, G_B);
      wait_d("ld", 127, 5, 127, d);
      query(G_B, 127, 1'b0);
      cfg_cmd(OP_LEAVE, G_B);
      check("ld_err", 64'(cfg_err), 64'(0));
      check("ld_quiet", 64'(rpt_valid), 64'(0));
      cycle();
      expect_now("ld_leave", T_LV, G_B);
      check("ld_map", 64'(active_map), 64'(4'b0000));

      // Asynchronous reset while a message is presented.
      cfg_cmd(OP_JOIN, G_C);
      cycle();
      check("ar_valid_before", 64'(rpt_valid), 64'(1));
      #3 rst = 1'b1;
      #1;
      check("ar_valid", 64'(rpt_valid),  64'(0));
      check("ar_type",  64'(rpt_type),   64'(0));
      check("ar_group", 64'(rpt_group),  64'(0));
      check("ar_map",   64'(active_map), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) cycle();
      check("ar_after", {rpt_valid, active_map}, {1'b0, 4'b0000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
